// File: rtl/hall_input_conditioner.sv
// Hall-sensor front end: synchronises and glitch-filters two raw hall channels,
// then decodes the quadrature sequence into levels, direction, step and status flags.
module hall_input_conditioner #(
  parameter int FILTER_CYCLES = 16,
  parameter int STALL_CYCLES  = 50000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic hall_1_raw,
  input  logic hall_2_raw,
  input  logic err_clr,
  output logic hall_1,
  output logic hall_2,
  output logic clockwise,
  output logic monitor,
  output logic step,
  output logic dir_err
);
  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  localparam int IW = $clog2(FILTER_CYCLES + 2) + 1;
  localparam int SW = $clog2(STALL_CYCLES) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(FILTER_CYCLES + 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STALL_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(STALL_CYCLES - 1);

  typedef enum logic {INIT, TRACK} state_t;

  // All channel pairs are packed as {channel 1, channel 2}.
  state_t          state, state_next;
  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      filt, filt_next;
  logic [FW-1:0]   fcnt [1:0];
  logic [FW-1:0]   fcnt_next [1:0];
  logic [IW-1:0]   icnt, icnt_next;
  logic [SW-1:0]   scnt, scnt_next;
  logic [1:0]      hall_r, hall_next, delta;
  logic            cw_r, cw_next;
  logic            mon_r, mon_next;
  logic            step_r, step_next;
  logic            err_r, err_next;
  logic            load;

  // Position along the clockwise cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase(input logic [1:0] h);
    return {h[0], h[1] ^ h[0]};
  endfunction

  assign load = (state == INIT) && (icnt == I_LAST);

  // Filter stage; on leaving INIT the filters snap to the synchronised levels
  // so the tracked outputs and the filtered levels start out equal.
  always_comb begin
    filt_next = filt;
    for (int i = 0; i < 2; i++) begin
      fcnt_next[i] = '0;
      if (load) begin
        filt_next[i] = sync_p1[i];
      end else if (sync_p1[i] != filt[i]) begin
        if (fcnt[i] == F_LAST) filt_next[i] = sync_p1[i];
        else                   fcnt_next[i] = fcnt[i] + 1'b1;
      end
    end
  end

  // Decode stage
  always_comb begin
    state_next = state;
    icnt_next  = icnt;
    scnt_next  = scnt;
    hall_next  = hall_r;
    cw_next    = cw_r;
    mon_next   = mon_r;
    step_next  = 1'b0;
    err_next   = err_clr ? 1'b0 : err_r;
    delta      = filt_next ^ hall_r;
    case (state)
      INIT: begin
        if (load) begin
          hall_next  = sync_p1;
          state_next = TRACK;
        end else begin
          icnt_next = icnt + 1'b1;
        end
      end
      TRACK: begin
        if (delta == 2'b11) begin
          hall_next = filt_next;
          err_next  = 1'b1;
          mon_next  = 1'b0;
          scnt_next = '0;
        end else if (delta != 2'b00) begin
          hall_next = filt_next;
          step_next = 1'b1;
          cw_next   = (phase(filt_next) == phase(hall_r) + 2'd1);
          mon_next  = 1'b1;
          scnt_next = '0;
        end else if (scnt != S_MAX) begin
          scnt_next = scnt + 1'b1;
          if (scnt == S_LAST) mon_next = 1'b0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= INIT;
      sync_p0 <= '0;
      sync_p1 <= '0;
      filt    <= '0;
      fcnt    <= '{default: '0};
      icnt    <= '0;
      scnt    <= '0;
      hall_r  <= '0;
      cw_r    <= 1'b1;
      mon_r   <= 1'b0;
      step_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_next;
      sync_p0 <= {hall_1_raw, hall_2_raw};
      sync_p1 <= sync_p0;
      filt    <= filt_next;
      fcnt    <= fcnt_next;
      icnt    <= icnt_next;
      scnt    <= scnt_next;
      hall_r  <= hall_next;
      cw_r    <= cw_next;
      mon_r   <= mon_next;
      step_r  <= step_next;
      err_r   <= err_next;
    end
  end

  assign hall_1    = hall_r[1];
  assign hall_2    = hall_r[0];
  assign clockwise = cw_r;
  assign monitor   = mon_r;
  assign step      = step_r;
  assign dir_err   = err_r;

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Directed bench for hall_input_conditioner; expected steps are queued when raw
// edges are driven and matched against each step pulse the DUT emits.
module tb_hall_input_conditioner;
  logic clk = 1'b0;
  logic n_reset, hall_1_raw, hall_2_raw, err_clr;
  logic hall_1, hall_2, clockwise, monitor, step, dir_err;
  logic [1:0] hall;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [1:0] hall;
    logic       cw;
  } exp_t;
  exp_t sb[$];
  exp_t pop_e;

  assign hall = {hall_1, hall_2};

  hall_input_conditioner #(.FILTER_CYCLES(16), .STALL_CYCLES(100)) dut (
    .clk(clk), .n_reset(n_reset), .hall_1_raw(hall_1_raw), .hall_2_raw(hall_2_raw),
    .err_clr(err_clr), .hall_1(hall_1), .hall_2(hall_2), .clockwise(clockwise),
    .monitor(monitor), .step(step), .dir_err(dir_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] v, input logic cw);
    exp_t e;
    e.cyc  = cyc + 18;
    e.hall = v;
    e.cw   = cw;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v, input logic cw);
    {hall_1_raw, hall_2_raw} = v;
    push_exp(v, cw);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk2({tag, "_hall"}, hall, 2'b00);
    chk1({tag, "_cw"}, clockwise, 1'b1);
    chk1({tag, "_monitor"}, monitor, 1'b0);
    chk1({tag, "_step"}, step, 1'b0);
    chk1({tag, "_dir_err"}, dir_err, 1'b0);
  endtask

  // Scoreboard: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      if (step === 1'b1) begin
        chk_int("step_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          pop_e = sb.pop_front();
          chk_int("step_cycle", cyc, pop_e.cyc);
          chk2("step_hall", hall, pop_e.hall);
          chk1("step_cw", clockwise, pop_e.cw);
          chk1("step_monitor", monitor, 1'b1);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        chk_int("step_missed_at", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cw_seq [4];
    int t, s;
    cw_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    n_reset = 1'b0;
    hall_1_raw = 1'b1;
    hall_2_raw = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Acquisition after reset release with raw=11
    n_reset = 1'b1;
    t = cyc;
    wait_cyc(t + 17);
    chk2("init_hold", hall, 2'b00);
    wait_cyc(t + 18);
    chk2("init_load", hall, 2'b11);
    chk1("init_monitor", monitor, 1'b0);
    chk1("init_cw", clockwise, 1'b1);
    chk1("init_dir_err", dir_err, 1'b0);

    // Walk clockwise to 00, then a full clockwise revolution
    drive(2'b01, 1'b1);
    repeat (40) @(negedge clk);
    drive(2'b00, 1'b1);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(cw_seq[i], 1'b1);
      repeat (40) @(negedge clk);
    end
    chk2("rev_hall", hall, 2'b00);
    chk1("rev_cw", clockwise, 1'b1);
    chk1("rev_monitor", monitor, 1'b1);

    // Illegal double change 00 -> 11
    t = cyc;
    {hall_1_raw, hall_2_raw} = 2'b11;
    wait_cyc(t + 17);
    chk1("illegal_pre_err", dir_err, 1'b0);
    wait_cyc(t + 18);
    chk2("illegal_hall", hall, 2'b11);
    chk1("illegal_err", dir_err, 1'b1);
    chk1("illegal_monitor", monitor, 1'b0);
    chk1("illegal_cw_held", clockwise, 1'b1);
    chk1("illegal_no_step", step, 1'b0);
    repeat (5) @(negedge clk);
    drive(2'b01, 1'b1);
    t = cyc;
    wait_cyc(t + 18);
    chk1("legal_restores_monitor", monitor, 1'b1);
    chk1("legal_keeps_err", dir_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk1("err_clr", dir_err, 1'b0);

    // Clockwise to 11, then reverse to 10
    repeat (20) @(negedge clk);
    drive(2'b00, 1'b1);
    repeat (40) @(negedge clk);
    drive(2'b10, 1'b1);
    repeat (40) @(negedge clk);
    drive(2'b11, 1'b1);
    repeat (40) @(negedge clk);
    drive(2'b10, 1'b0);
    t = cyc;
    wait_cyc(t + 17);
    chk2("rev_pre_hall", hall, 2'b11);
    wait_cyc(t + 18);
    chk1("rev_hall_2", hall_2, 1'b0);
    chk1("rev_step", step, 1'b1);
    chk1("rev_cw_flip", clockwise, 1'b0);

    // Glitch rejection: 15-cycle pulse dropped, 17-cycle pulse passes
    repeat (22) @(negedge clk);
    drive(2'b11, 1'b1);
    repeat (40) @(negedge clk);
    hall_2_raw = 1'b0;
    repeat (15) @(negedge clk);
    hall_2_raw = 1'b1;
    repeat (40) @(negedge clk);
    chk2("glitch15_hall", hall, 2'b11);
    hall_2_raw = 1'b0;
    push_exp(2'b10, 1'b0);
    repeat (17) @(negedge clk);
    hall_2_raw = 1'b1;
    push_exp(2'b11, 1'b1);
    s = cyc + 18;

    // Stall timeout
    wait_cyc(s + 99);
    chk1("stall_before", monitor, 1'b1);
    wait_cyc(s + 100);
    chk1("stall_fall", monitor, 1'b0);
    chk1("stall_cw_held", clockwise, 1'b1);
    chk2("stall_hall", hall, 2'b11);

    // Illegal edge coinciding with err_clr: the set wins
    drive(2'b10, 1'b0);
    repeat (40) @(negedge clk);
    t = cyc;
    {hall_1_raw, hall_2_raw} = 2'b01;
    wait_cyc(t + 17);
    err_clr = 1'b1;
    wait_cyc(t + 18);
    err_clr = 1'b0;
    chk1("set_wins_err", dir_err, 1'b1);
    chk1("set_wins_monitor", monitor, 1'b0);
    chk1("set_wins_cw_held", clockwise, 1'b0);
    chk2("set_wins_hall", hall, 2'b01);
    repeat (5) @(negedge clk);
    drive(2'b11, 1'b0);
    repeat (25) @(negedge clk);
    chk1("pre_reset_monitor", monitor, 1'b1);
    chk1("pre_reset_err", dir_err, 1'b1);

    // Asynchronous reset mid-run, then reacquisition without a step
    #3;
    n_reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    t = cyc;
    wait_cyc(t + 17);
    chk2("reacq_hold", hall, 2'b00);
    wait_cyc(t + 18);
    chk2("reacq_hall", hall, 2'b11);
    chk1("reacq_monitor", monitor, 1'b0);
    chk1("reacq_cw", clockwise, 1'b1);
    repeat (5) @(negedge clk);
    chk_int("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
